// File: rtl/ctrl_div_pkg.sv
// Shared definitions for the ctrl_div restoring divider controller:
// FSM state encoding, default operand width and counter width helper.
package ctrl_div_pkg;

  localparam int DIV_WIDTH = 16;

  // Iteration counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SUB   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ctrl_div_sub_cmp.sv
// Compare/subtract slice of the divider: A - divisor in WIDTH+1 bits.
// ge is the inverted borrow (A >= divisor, unsigned); result is the low WIDTH bits.
module sub_cmp_div #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             ge
);

  logic [WIDTH:0] diff;

  // One extra bit turns the subtraction borrow into the compare result.
  always_comb begin
    diff   = {1'b0, A} - {1'b0, divisor};
    result = diff[WIDTH-1:0];
    ge     = ~diff[WIDTH];
  end

endmodule

// File: rtl/ctrl_div.sv
// ctrl_div: sequencing FSM for a restoring divider whose {A,dividend}
// shift/accumulate stage lives downstream and samples init/sh/load_A on the
// falling edge. Optional divide-by-zero short cut under macro DIV_ZERO_CHECK_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; operands latched on accept
//   ST_INIT  | init high: shift stage clears A and loads the dividend
//   ST_SHIFT | sh high: {A,dividend} shifted left by one
//   ST_SUB   | load_A high when A >= divisor; counter decremented
//   ST_DONE  | remainder captured; done pulses on the way back to IDLE
//
// Control outputs are registered and decided on the edge that enters the
// state they belong to, so the SUB decision uses A as left by the shift.
module ctrl_div
  import ctrl_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dr_in,
  input  logic [WIDTH-1:0] dv_in,
  input  logic [WIDTH-1:0] A,
  output logic             init,
  output logic             sh,
  output logic             load_A,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dr_q;
  logic               init_q;
  logic               sh_q;
  logic               load_a_q;
  logic               busy_q;
  logic               done_q;
  logic               ge;
`ifdef DIV_ZERO_CHECK_EN
  logic [WIDTH-1:0]   dv_q;
  logic               dz_q;
`endif

  sub_cmp_div #(
    .WIDTH(WIDTH)
  ) u_sub_cmp (
    .A      (A),
    .divisor(dr_q),
    .result (result),
    .ge     (ge)
  );

  // Next values for the iteration counter and the quotient shift register.
  always_comb begin
    cnt_d  = cnt_q - CNT_W'(1);
    quot_d = {quot_q[WIDTH-2:0], ge};
  end

  // Sequencing FSM with registered control and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dr_q     <= '0;
      init_q   <= 1'b0;
      sh_q     <= 1'b0;
      load_a_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dv_q     <= '0;
      dz_q     <= 1'b0;
`endif
    end else begin
      init_q   <= 1'b0;
      sh_q     <= 1'b0;
      load_a_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dr_q   <= dr_in;
            quot_q <= '0;
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            dv_q   <= dv_in;
            dz_q   <= 1'b0;
            if (dr_in == '0) begin
              quot_q  <= '1;
              state_q <= ST_DONE;
            end else begin
              init_q  <= 1'b1;
              state_q <= ST_INIT;
            end
`else
            init_q  <= 1'b1;
            state_q <= ST_INIT;
`endif
          end
        end
        ST_INIT: begin
          sh_q    <= 1'b1;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          load_a_q <= ge;
          quot_q   <= quot_d;
          state_q  <= ST_SUB;
        end
        ST_SUB: begin
          cnt_q <= cnt_d;
          if (cnt_d != '0) begin
            sh_q    <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`ifdef DIV_ZERO_CHECK_EN
          if (dr_q == '0) begin
            rem_q <= dv_q;
            dz_q  <= 1'b1;
          end else begin
            rem_q <= A;
          end
`else
          rem_q <= A;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign init      = init_q;
  assign sh        = sh_q;
  assign load_A    = load_a_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ZERO_CHECK_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule
